dp_ram_ctrl: RTL

- Parametrised true dual-port synchronous RAM; next generation of the 32x8 dual-port store.
- Adds configurable width and depth, a power-up memory clear sequencer, and defined collision resolution.
- Adds per-port read-valid flags and a collision indicator.
- Used as the shared buffer between two independent masters on one clock domain.

---
 rtl/dp_ram_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dp_ram_ctrl.sv
// -----------------------------------------------------------------------------
// dp_ram_ctrl
// Parametrised true dual-port synchronous RAM shared by two masters on a single
// clock. After reset an optional sequencer clears the whole array. Same-address
// conflicts between the ports are resolved deterministically and flagged with a
// one-cycle collision pulse.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   cs                  chip select shared by both ports
//   a_we/a_re/a_oe      port A write, read and output enables
//   a_addr/a_din        port A address and write data
//   a_dout/a_valid      port A read data and "captured last cycle" flag
//   b_*                 port B, identical to port A
//   busy                clear sequencer running, all requests ignored
//   collision           a same-address conflict was resolved last cycle
// -----------------------------------------------------------------------------
module dp_ram_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int WR_PRIO  = 0,
  parameter int RD_MODE  = 0,
  parameter int IDLE_VAL = 1,
  parameter int INIT_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              a_we,
  input  logic              a_re,
  input  logic              a_oe,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_we,
  input  logic              b_re,
  input  logic              b_oe,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  output logic              busy,
  output logic              collision
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] IDLE_WORD = DATA_W'(IDLE_VAL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic              B_WINS    = 1'(WR_PRIO != 0);
  localparam logic              WR_THRU   = 1'(RD_MODE != 0);
  localparam logic              RST_BUSY  = 1'(INIT_EN != 0);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam state_e RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_READY;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                a_valid_q, a_valid_d;
  logic                b_valid_q, b_valid_d;
  logic                a_hold_q, a_hold_d;
  logic                b_hold_q, b_hold_d;
  logic                coll_q, coll_d;

  logic                act_s;
  logic                a_wr_s, a_rd_s, b_wr_s, b_rd_s;
  logic                same_addr_s;
  logic                wr_clash_s;
  logic                a_wr_keep_s, b_wr_keep_s;

  // Sequencer next state: walk init_cnt over every word, then park in READY.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
    busy_d = (state_d == ST_INIT);
  end

  // Request qualification and conflict resolution between the two ports.
  always_comb begin
    act_s       = (state_q == ST_READY) & cs;
    a_wr_s      = act_s & a_we;
    a_rd_s      = act_s & a_re;
    b_wr_s      = act_s & b_we;
    b_rd_s      = act_s & b_re;
    same_addr_s = (a_addr == b_addr);
    wr_clash_s  = a_wr_s & b_wr_s & same_addr_s;
    // The losing write of a same-address clash is dropped entirely.
    a_wr_keep_s = a_wr_s & ~(wr_clash_s & B_WINS);
    b_wr_keep_s = b_wr_s & ~(wr_clash_s & ~B_WINS);
    coll_d      = same_addr_s & ((a_wr_s & b_wr_s) |
                                 (a_rd_s & b_wr_s) |
                                 (b_rd_s & a_wr_s));
  end

  // Read data selection: a port never forwards its own write, only the other's.
  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_rd_s) begin
      if (WR_THRU && b_wr_s && same_addr_s) begin
        a_rdata_d = b_din;
      end else begin
        a_rdata_d = mem_q[a_addr];
      end
    end else begin
      a_rdata_d = a_rdata_q;
    end
    if (b_rd_s) begin
      if (WR_THRU && a_wr_s && same_addr_s) begin
        b_rdata_d = a_din;
      end else begin
        b_rdata_d = mem_q[b_addr];
      end
    end else begin
      b_rdata_d = b_rdata_q;
    end
    a_valid_d = a_rd_s;
    b_valid_d = b_rd_s;
    a_hold_d  = a_hold_q | a_rd_s;
    b_hold_d  = b_hold_q | b_rd_s;
  end

  // Control and read-path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
      busy_q     <= RST_BUSY;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      a_hold_q   <= 1'b0;
      b_hold_q   <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      busy_q     <= busy_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
      coll_q     <= coll_d;
    end
  end

  // Storage array: no reset, cleared only by the sequencer.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else begin
      if (a_wr_keep_s) begin
        mem_q[a_addr] <= a_din;
      end
      if (b_wr_keep_s) begin
        mem_q[b_addr] <= b_din;
      end
    end
  end

  // Until a port has read once its register holds no real data, so keep IDLE.
  assign a_dout    = (cs & a_oe & a_hold_q) ? a_rdata_q : IDLE_WORD;
  assign b_dout    = (cs & b_oe & b_hold_q) ? b_rdata_q : IDLE_WORD;
  assign a_valid   = a_valid_q;
  assign b_valid   = b_valid_q;
  assign busy      = busy_q;
  assign collision = coll_q;

endmodule
